mem_access_unit: RTL
====================

# mem_access_unit

Load/store access controller between the execute/mem pipeline stage and `data_ram`. It accepts one byte, halfword or word load/store request at a time and converts it into word-aligned RAM accesses. Byte stores become read-merge-write, and accesses that cross a word boundary are split into two accesses. Load results are returned zero- or sign-extended with a one-cycle valid pulse.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data and RAM word width; fixed at 32 for this block.

Ports:
- `i_Clk` in 1: single clock. All state changes on the rising edge.
- `i_reset` in 1: reset is synchronous and active-high (`ResetEnable`).
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: unit can accept; high only in IDLE and not in reset.
- `i_req_we` in 1: 1 = store, 0 = load.
- `i_req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `i_req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `i_req_addr` in ADDR_W: byte address; any alignment is allowed.
- `i_req_wdata` in DATA_W: store data in the low-order bytes.
- `o_rsp_valid` out 1: one-cycle completion pulse for loads and stores.
- `o_rsp_rdata` out DATA_W: extended load data; 0 for stores.
- `o_rsp_split` out 1: qualifies `o_rsp_valid`; the access crossed a word boundary.
- `o_ram_we` out 1: `data_ram` write enable.
- `o_ram_w_addr` out ADDR_W: word-aligned write address.
- `o_ram_w_data` out DATA_W: merged write word.
- `o_ram_r_addr` out ADDR_W: word-aligned read address; the RAM read is combinational.
- `i_ram_r_data` in DATA_W: `data_ram` read data, valid in the same cycle.

## Operation
- FSM states: IDLE, ACC_LO, ACC_HI, RESP. Reset state is IDLE.
- IDLE
  - `o_req_ready`=1.
  - On `i_req_valid`, latch we, size, unsigned, addr and wdata, then go to ACC_LO.
- Derived values
  - off = addr[1:0].
  - nbytes = 1, 2 or 4.
  - split = (off + nbytes > 4).
- ACC_LO
  - `o_ram_r_addr` = `o_ram_w_addr` = {addr[31:2],2'b00}.
  - Lanes off..min(3, off+nbytes−1) take the store bytes, lowest byte first.
  - Store: write `i_ram_r_data` with those lanes replaced, `o_ram_we`=1.
  - Load: capture the same lanes into the byte-assembly register.
  - Next state is ACC_HI if split, else RESP.
- ACC_HI
  - Address is {addr[31:2],2'b00}+4, computed modulo 2^ADDR_W, so 0xFFFFFFFC+4 wraps to 0x00000000.
  - The remaining bytes map to lanes 0.. in order.
  - Store merges and writes; load captures.
  - Next state is RESP.
- RESP
  - `o_rsp_valid`=1 and `o_rsp_split`=split.
  - `o_rsp_rdata` = assembled bytes extended to 32 bits. Sign bit is bit 7 for byte, bit 15 for half, none for word.
  - Next state is IDLE.
- `o_ram_we`=0 in IDLE and RESP.
- Reset values: all outputs 0, including `o_req_ready` (0 while `i_reset`=1). State returns to IDLE and latched fields clear.
- Reset mid-operation: the access is abandoned, there is no write in the reset cycle, and no response is issued. A word already written in ACC_LO stays written.

## Timing
- Request is accepted in cycle 0; ACC_LO is cycle 1.
- Non-split access: RESP in cycle 2, so `o_rsp_valid` is high 2 cycles after acceptance.
- Split access: ACC_HI in cycle 2, RESP in cycle 3.
- `o_req_ready` returns high in the cycle after RESP. Back-to-back throughput is therefore one request per 3 cycles (non-split) or 4 cycles (split).
- `i_req_*` are ignored when `o_req_ready`=0.
- RAM read data is sampled in the same cycle it is addressed. RAM writes commit on the edge that ends ACC_LO or ACC_HI.

## Structure
- `defines.v` carries:
  - size codes `SizeByte`, `SizeHalf`, `SizeWord`;
  - FSM state encodings;
  - reuse of `RAMAddrBus`, `RAMDataBus`, `ZeroWord`, `WriteEnable`, `ResetEnable`.
- One combinational sub-module, `mem_lane_align`: given off, nbytes, half (LO/HI), old word and store data, it produces the merged word and the extracted bytes. It is instantiated once and muxed by state.

## Test plan
- SW 0x12345678 at 0x10, then LW 0x10 → `o_rsp_rdata`=0x12345678, valid 2 cycles after acceptance, `o_rsp_split`=0.
- RAM word 0x10 = 0x11223344; SB 0xAB at 0x13 → word becomes 0xAB223344. Then LB 0x13 → 0xFFFFFFAB; LBU 0x13 → 0x000000AB.
- Zeroed RAM; SW 0xAABBCCDD at 0x0F → word 0x0C = 0xDD000000, word 0x10 = 0x00AABBCC. Then LW 0x0F → 0xAABBCCDD, valid 3 cycles after acceptance, `o_rsp_split`=1.
- LH at 0xFFFFFFFF → ACC_HI drives `o_ram_r_addr`=0x00000000. With byte 0xFFFFFFFF = 0x80 and byte 0x0 = 0x7F, result is 0x00007F80.
- Split SW at 0x0F with `i_reset` asserted during ACC_HI → `o_ram_we`=0 that cycle, word 0x10 unchanged, no `o_rsp_valid`. `o_req_ready`=1 the first cycle after reset release.
- `i_req_valid` held high with aligned loads → accepts on cycles 0, 3, 6; `o_req_ready`=0 in ACC_LO and RESP.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared constants, size codes, FSM state encoding, the latched request
//   struct and small helpers used by the load/store access controller.
package mem_access_unit_pkg;

  localparam int RAMAddrBus = 32;
  localparam int RAMDataBus = 32;
  localparam logic [RAMDataBus-1:0] ZeroWord = '0;
  localparam logic WriteEnable = 1'b1;
  localparam logic ResetEnable = 1'b1;

  // byte lanes per RAM word
  localparam int NUM_LANES = 4;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_LO = 2'd1,
    ST_ACC_HI = 2'd2,
    ST_RESP   = 2'd3
  } mau_state_e;

  // request fields held for the whole access (address kept separately,
  // its width is a module parameter)
  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [RAMDataBus-1:0] wdata;
  } mau_req_t;

  // size code 11 behaves as a word
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SizeByte: return 3'd1;
      SizeHalf: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  // bytes above the access size are already zero in the assembly register,
  // so only the sign fill has to be produced here
  function automatic logic [RAMDataBus-1:0] load_extend(input logic [RAMDataBus-1:0] raw,
                                                        input logic [1:0] size,
                                                        input logic uns);
    case (size)
      SizeByte: return {{24{~uns & raw[7]}}, raw[7:0]};
      SizeHalf: return {{16{~uns & raw[15]}}, raw[15:0]};
      default:  return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align
//   Combinational byte-lane steering for one RAM word access.
//   Ports:
//     off      - byte offset of the access inside its first word
//     nbytes   - access size in bytes (1, 2, 4)
//     half_hi  - 0: first (low) word of the access, 1: second (high) word
//     old_word - current RAM word (read data)
//     st_data  - store data, access byte 0 in lane 0
//     merged   - old_word with this half's store bytes substituted
//     ld_bytes - load bytes indexed by access byte number
//     ld_en    - which ld_bytes entries belong to this half
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]                 off,
  input  logic [2:0]                 nbytes,
  input  logic                       half_hi,
  input  logic [NUM_LANES-1:0][7:0]  old_word,
  input  logic [NUM_LANES-1:0][7:0]  st_data,
  output logic [NUM_LANES-1:0][7:0]  merged,
  output logic [NUM_LANES-1:0][7:0]  ld_bytes,
  output logic [NUM_LANES-1:0]       ld_en
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    // access byte number carried by RAM lane l. In the low half, lanes
    // below off wrap to 5..7, which is never < nbytes, so they stay clear.
    logic [2:0] k;
    logic       en;
    assign k      = half_hi ? (3'(l) + 3'd4 - {1'b0, off}) : (3'(l) - {1'b0, off});
    assign en     = (k < nbytes);
    assign merged[l] = en ? st_data[k[1:0]] : old_word[l];
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_byte
    // absolute lane of access byte j; bit 2 says which word it lives in
    logic [2:0] ln;
    assign ln          = {1'b0, off} + 3'(j);
    assign ld_en[j]    = (3'(j) < nbytes) && (ln[2] == half_hi);
    assign ld_bytes[j] = old_word[ln[1:0]];
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store controller between the mem stage and data_ram. One request
//   at a time; any alignment; word-crossing accesses take two RAM cycles.
//   Stores are read-merge-write on a combinational-read RAM.
//   Ports:
//     i_Clk, i_reset          - clock, synchronous active-high reset
//     i_req_*/o_req_ready     - request handshake and fields
//     o_rsp_valid/rdata/split - one-cycle completion pulse with load data
//     o_ram_*/i_ram_r_data    - word-aligned data_ram port
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_Clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_split,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_w_addr,
  output logic [DATA_W-1:0] o_ram_w_data,
  output logic [ADDR_W-1:0] o_ram_r_addr,
  input  logic [DATA_W-1:0] i_ram_r_data
);

  mau_state_e state_q, state_d;
  mau_req_t   req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NUM_LANES-1:0][7:0] asm_q;

  logic accept, capture;

  // derived access geometry
  logic [1:0] off;
  logic [2:0] nbytes;
  logic       split;
  logic [ADDR_W-1:0] word_addr, hi_addr, acc_addr;

  assign off       = addr_q[1:0];
  assign nbytes    = size_nbytes(req_q.size);
  assign split     = ({1'b0, off} + nbytes) > 3'd4;
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign hi_addr   = word_addr + ADDR_W'(4);   // wraps at the top of memory
  assign acc_addr  = (state_q == ST_ACC_HI) ? hi_addr : word_addr;

  logic [NUM_LANES-1:0][7:0] old_word, st_data, merged, ld_bytes;
  logic [NUM_LANES-1:0]      ld_en;

  assign old_word = i_ram_r_data;
  assign st_data  = req_q.wdata;

  mem_lane_align u_align (
    .off      (off),
    .nbytes   (nbytes),
    .half_hi  (state_q == ST_ACC_HI),
    .old_word (old_word),
    .st_data  (st_data),
    .merged   (merged),
    .ld_bytes (ld_bytes),
    .ld_en    (ld_en)
  );

  always_ff @(posedge i_Clk) begin
    if (i_reset == ResetEnable) state_q <= ST_IDLE;
    else                        state_q <= state_d;
  end

  // Outputs are forced to zero while reset is high so that a reset landing
  // in an access cycle cannot leak a write to the RAM.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    capture      = 1'b0;
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_rsp_split  = 1'b0;
    o_rsp_rdata  = '0;
    o_ram_we     = 1'b0;
    o_ram_w_addr = '0;
    o_ram_r_addr = '0;
    o_ram_w_data = '0;
    if (i_reset != ResetEnable) begin
      case (state_q)
        ST_IDLE: begin
          o_req_ready = 1'b1;
          if (i_req_valid) begin
            accept  = 1'b1;
            state_d = ST_ACC_LO;
          end
        end
        ST_ACC_LO, ST_ACC_HI: begin
          o_ram_r_addr = acc_addr;
          o_ram_w_addr = acc_addr;
          if (req_q.we) begin
            o_ram_we     = WriteEnable;
            o_ram_w_data = merged;
          end else begin
            capture = 1'b1;
          end
          state_d = (state_q == ST_ACC_LO && split) ? ST_ACC_HI : ST_RESP;
        end
        ST_RESP: begin
          o_rsp_valid = 1'b1;
          o_rsp_split = split;
          o_rsp_rdata = req_q.we ? ZeroWord : load_extend(asm_q, req_q.size, req_q.uns);
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_reset == ResetEnable) begin
      req_q  <= '0;
      addr_q <= '0;
      asm_q  <= '0;
    end else begin
      if (accept) begin
        req_q  <= '{we: i_req_we, size: i_req_size, uns: i_req_unsigned, wdata: i_req_wdata};
        addr_q <= i_req_addr;
        asm_q  <= '0;   // unused upper bytes must read as zero
      end
      if (capture) begin
        for (int j = 0; j < NUM_LANES; j++)
          if (ld_en[j]) asm_q[j] <= ld_bytes[j];
      end
    end
  end

endmodule
